// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter.
//   state_t              - arbiter FSM state encoding
//   DEFAULT_BUSY_TIMEOUT - default cycle budget for the master to raise ready_n
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4,
        ABORT     = 3'd5
    } state_t;

    localparam int DEFAULT_BUSY_TIMEOUT = 1023;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently served requester
//   valid      - at least one request is pending
//   grant      - winning index; search starts at (last_grant+1) mod N_REQ
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic             valid,
    output logic [GW-1:0]    grant
);

    // Walk from the lowest priority candidate up to the highest so the
    // final assignment that sticks belongs to the highest-priority requester.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        valid = |req;
        grant = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % N_REQ])
                grant = GW'((int'(last_grant) + i) % N_REQ);
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between N_REQ requesters.
//   clk, reset        - system clock, synchronous active-high reset
//   req/req_rd        - per-requester request level and direction (1 = read)
//   req_addr/req_data - per-requester 7-bit device address / {reg, byte}
//   ack/err           - one-cycle completion / timeout pulse to the grantee
//   rd_data           - read byte, valid with ack of a read
//   busy              - arbiter is not IDLE
//   start_write/read  - one-cycle strobes to the master
//   address/data      - command latched at grant time, held until done
//   ready_n           - master busy flag; master_rd_data valid on its fall
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_rd,
    input  logic [7*N_REQ-1:0]  req_addr,
    input  logic [16*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    err,
    output logic [7:0]          rd_data,
    output logic                busy,
    output logic                start_write,
    output logic                start_read,
    output logic [6:0]          address,
    output logic [15:0]         data,
    input  logic                ready_n,
    input  logic [7:0]          master_rd_data
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t          state, state_next;
    logic [GW-1:0]   grant, grant_next;
    logic [GW-1:0]   last_grant, last_grant_next;
    logic [CW-1:0]   count, count_next;
    logic            rd_q, rd_next;
    logic [N_REQ-1:0] ack_next, err_next;
    logic [7:0]      rd_data_next;
    logic            start_write_next, start_read_next;
    logic [6:0]      address_next;
    logic [15:0]     data_next;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;

    rr_picker #(.N_REQ(N_REQ), .GW(GW)) u_rr_picker (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_idx)
    );

    assign busy = (state != IDLE);

    // Every output is registered; this block computes the values they take
    // at the next edge, so ack/err are high during FINISH/ABORT and the
    // start strobe is high in the cycle after ISSUE.
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        last_grant_next  = last_grant;
        count_next       = count;
        rd_next          = rd_q;
        address_next     = address;
        data_next        = data;
        rd_data_next     = rd_data;
        ack_next         = '0;
        err_next         = '0;
        start_write_next = 1'b0;
        start_read_next  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next   = pick_idx;
                    rd_next      = req_rd[pick_idx];
                    address_next = req_addr[7*pick_idx +: 7];
                    data_next    = req_data[16*pick_idx +: 16];
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                start_write_next = ~rd_q;
                start_read_next  = rd_q;
                count_next       = '0;
                state_next       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Wrap on the exit cycle is harmless: the counter is
                // cleared again before it is next consulted.
                count_next = count + CW'(1);
                if (ready_n) begin
                    state_next = WAIT_DONE;
                end else if (count == CW'(BUSY_TIMEOUT)) begin
                    err_next[grant] = 1'b1;
                    state_next      = ABORT;
                end
            end
            WAIT_DONE: begin
                if (!ready_n) begin
                    if (rd_q)
                        rd_data_next = master_rd_data;
                    ack_next[grant] = 1'b1;
                    state_next      = FINISH;
                end
            end
            FINISH, ABORT: begin
                last_grant_next = grant;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GW'(N_REQ - 1);
            count       <= '0;
            rd_q        <= 1'b0;
            address     <= '0;
            data        <= '0;
            rd_data     <= '0;
            ack         <= '0;
            err         <= '0;
            start_write <= 1'b0;
            start_read  <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_grant  <= last_grant_next;
            count       <= count_next;
            rd_q        <= rd_next;
            address     <= address_next;
            data        <= data_next;
            rd_data     <= rd_data_next;
            ack         <= ack_next;
            err         <= err_next;
            start_write <= start_write_next;
            start_read  <= start_read_next;
        end
    end

endmodule
